// File: rtl/data_mem.sv
// Data memory stage for the single-cycle RV32I core: byte/half/word loads and
// stores on a little-endian word array, with combinational reads and edge-committed writes.
module data_mem #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        fault
);

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic [31:0]      rd_word;
  logic [31:0]      wr_word_d;
  logic [31:0]      wr_rep;
  logic [3:0]       byte_en;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic             misaligned;
  logic             out_of_range;
  logic             illegal;

  assign word_idx = addr[IDX_W+1:2];
  assign lane     = addr[1:0];
  assign rd_word  = mem_q[word_idx];

  // Power-of-two depth lets the full 32-bit range test reduce to "any bit above the array is set".
  assign out_of_range = (addr >> (IDX_W + 2)) != 32'd0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    illegal    = 1'b0;
    misaligned = 1'b0;
    unique case (funct3)
      F3_B:         ;
      F3_H:         misaligned = addr[0];
      F3_W:         misaligned = (lane != 2'b00);
      F3_BU:        illegal    = mem_write;
      F3_HU: begin
        illegal    = mem_write;
        misaligned = addr[0];
      end
      default:      illegal    = 1'b1;
    endcase
  end

  assign fault = (mem_read | mem_write) & (misaligned | out_of_range | illegal);

  // Store merge: replicate the store data across lanes, then pick lanes by byte enable.
  always_comb begin
    byte_en = 4'b0000;
    wr_rep  = wdata;
    case (funct3)
      F3_B: begin
        byte_en = 4'b0001 << lane;
        wr_rep  = {4{wdata[7:0]}};
      end
      F3_H: begin
        byte_en = addr[1] ? 4'b1100 : 4'b0011;
        wr_rep  = {2{wdata[15:0]}};
      end
      F3_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
    for (int b = 0; b < 4; b++) begin
      wr_word_d[8*b +: 8] = byte_en[b] ? wr_rep[8*b +: 8] : rd_word[8*b +: 8];
    end
  end

  assign rd_byte = rd_word[8*lane +: 8];
  assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rdata = 32'd0;
    if (mem_read && !fault) begin
      case (funct3)
        F3_B:    rdata = {{24{rd_byte[7]}}, rd_byte};
        F3_BU:   rdata = {24'd0, rd_byte};
        F3_H:    rdata = {{16{rd_half[15]}}, rd_half};
        F3_HU:   rdata = {16'd0, rd_half};
        F3_W:    rdata = rd_word;
        default: rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the memory is cleared on reset by design, so it maps to flops rather than a RAM macro.
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (mem_write && !fault) begin
      mem_q[word_idx] <= wr_word_d;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: a table of one-cycle vectors with expected
// combinational outputs, plus a hand-written fill-then-reset sequence.
module tb_data_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] rdata;
  logic        fault;

  int checks = 0;
  int errors = 0;

  data_mem #(.DEPTH_WORDS(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .rdata     (rdata),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic rd, logic wr, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] wd,
                              logic [31:0] er, logic ef);
    vec_t v;
    v.rst = r; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_fault = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One cycle: drive after the falling edge, sample 1 ns later, commit on the next rising edge.
  task automatic apply(input logic r, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    rst = r; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    #1;
  endtask

  initial begin
    // rst rd wr f3 addr wdata exp_rdata exp_fault
    vecs.push_back(mk(1, 0, 0, 3'b010, 32'h0,    32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h10,   32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 3'b010, 32'h10,   32'hAAAA5555, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h10,   32'h0,        32'hAAAA5555, 0));
    vecs.push_back(mk(0, 0, 1, 3'b010, 32'h20,   32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 3'b000, 32'h22,   32'h000000F0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h20,   32'h0,        32'h00F00000, 0));
    vecs.push_back(mk(0, 1, 0, 3'b000, 32'h22,   32'h0,        32'hFFFFFFF0, 0));
    vecs.push_back(mk(0, 1, 0, 3'b100, 32'h22,   32'h0,        32'h000000F0, 0));
    vecs.push_back(mk(0, 0, 1, 3'b010, 32'h30,   32'h5555AAAA, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 3'b001, 32'h30,   32'h0,        32'hFFFFAAAA, 0));
    vecs.push_back(mk(0, 1, 0, 3'b101, 32'h32,   32'h0,        32'h00005555, 0));
    vecs.push_back(mk(0, 0, 1, 3'b001, 32'h32,   32'h00001234, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h30,   32'h0,        32'h1234AAAA, 0));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h31,   32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 0, 1, 3'b001, 32'h33,   32'h0000FFFF, 32'h0,        1));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h30,   32'h0,        32'h1234AAAA, 0));
    vecs.push_back(mk(0, 0, 1, 3'b011, 32'h30,   32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h30,   32'h0,        32'h1234AAAA, 0));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h1000, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 0, 1, 3'b010, 32'h1000, 32'h00000001, 32'h0,        1));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h0,    32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 3'b010, 32'hFFC,  32'hCAFEF00D, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'hFFC,  32'h0,        32'hCAFEF00D, 0));
    vecs.push_back(mk(0, 0, 1, 3'b010, 32'h40,   32'h11111111, 32'h0,        0));
    vecs.push_back(mk(0, 1, 1, 3'b010, 32'h40,   32'h22222222, 32'h11111111, 0));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h40,   32'h0,        32'h22222222, 0));
    vecs.push_back(mk(0, 0, 1, 3'b000, 32'h63,   32'h0000007F, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 3'b000, 32'h63,   32'h0,        32'h0000007F, 0));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h60,   32'h0,        32'h7F000000, 0));
    vecs.push_back(mk(0, 0, 1, 3'b100, 32'h64,   32'h00000077, 32'h0,        1));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h64,   32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 3'b101, 32'h61,   32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 1, 0, 3'b110, 32'h40,   32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 0, 1, 3'b010, 32'h50,   32'hDEADBEEF, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h50,   32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h10,   32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h40,   32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 3'b010, 32'h31,   32'h0,        32'h0,        0));

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d fault", i), {31'd0, fault}, {31'd0, vecs[i].exp_fault});
    end

    // Fill four words, read one back, reset, then confirm all four are cleared.
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 1, 3'b010, 32'h100 + 32'(4 * k), 32'hA5A50000 + 32'(k));
    end
    apply(0, 1, 0, 3'b010, 32'h108, 32'h0);
    check("fill readback", rdata, 32'hA5A50002);
    apply(1, 1, 0, 3'b010, 32'h108, 32'h0);
    check("read during reset cycle", rdata, 32'hA5A50002);
    for (int k = 0; k < 4; k++) begin
      apply(0, 1, 0, 3'b010, 32'h100 + 32'(4 * k), 32'h0);
      check($sformatf("post-reset word%0d", k), rdata, 32'h0);
    end

    // Halfword store to the low half leaves the high half alone.
    apply(0, 0, 1, 3'b010, 32'h200, 32'h89ABCDEF);
    apply(0, 0, 1, 3'b001, 32'h200, 32'hFFFF8001);
    apply(0, 1, 0, 3'b010, 32'h200, 32'h0);
    check("sh low lane merge", rdata, 32'h89AB8001);
    apply(0, 1, 0, 3'b001, 32'h202, 32'h0);
    check("lh high sign", rdata, 32'hFFFF89AB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
